// File: rtl/mips_defs.sv
// Shared MIPS pipeline definitions: memory opcodes, exception codes and
// access-size decode used by the memory stage, decoder and hazard unit.
package mips_defs;

    localparam logic [5:0] OP_LW  = 6'h23;
    localparam logic [5:0] OP_LH  = 6'h21;
    localparam logic [5:0] OP_LHU = 6'h25;
    localparam logic [5:0] OP_LB  = 6'h20;
    localparam logic [5:0] OP_LBU = 6'h24;
    localparam logic [5:0] OP_SW  = 6'h2B;
    localparam logic [5:0] OP_SH  = 6'h29;
    localparam logic [5:0] OP_SB  = 6'h28;

    localparam logic [1:0] EXC_NONE = 2'd0;
    localparam logic [1:0] EXC_ADEL = 2'd1;
    localparam logic [1:0] EXC_ADES = 2'd2;

    typedef enum logic [1:0] {
        SZ_NONE = 2'd0,
        SZ_BYTE = 2'd1,
        SZ_HALF = 2'd2,
        SZ_WORD = 2'd3
    } mem_size_e;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc4;
        logic [31:0] pc8;
        logic [31:0] ao;
        logic [31:0] dr;
        logic        regw;
        logic [1:0]  exc;
    } wb_reg_t;

    function automatic mem_size_e access_size(input logic [5:0] op);
        case (op)
            OP_LW, OP_SW:          return SZ_WORD;
            OP_LH, OP_LHU, OP_SH:  return SZ_HALF;
            OP_LB, OP_LBU, OP_SB:  return SZ_BYTE;
            default:               return SZ_NONE;
        endcase
    endfunction

    function automatic logic is_load_op(input logic [5:0] op);
        return (op == OP_LW) || (op == OP_LH) || (op == OP_LHU) ||
               (op == OP_LB) || (op == OP_LBU);
    endfunction

    function automatic logic is_store_op(input logic [5:0] op);
        return (op == OP_SW) || (op == OP_SH) || (op == OP_SB);
    endfunction

endpackage

// File: rtl/mem_wb_stage_if.sv
// EX/MEM-side inputs and MEM/WB-side outputs of the memory stage.
interface mem_wb_stage_if;
    logic [31:0] instr_M;
    logic [31:0] PC4_M;
    logic [31:0] PC8_M;
    logic [31:0] AO_M;
    logic [31:0] MEMD_M;
    logic        RegW_M;

    logic [31:0] instr_W;
    logic [31:0] PC4_W;
    logic [31:0] PC8_W;
    logic [31:0] AO_W;
    logic [31:0] DR_W;
    logic        RegW_W;
    logic [1:0]  exc_W;

    modport master (
        output instr_M, PC4_M, PC8_M, AO_M, MEMD_M, RegW_M,
        input  instr_W, PC4_W, PC8_W, AO_W, DR_W, RegW_W, exc_W
    );

    modport slave (
        input  instr_M, PC4_M, PC8_M, AO_M, MEMD_M, RegW_M,
        output instr_W, PC4_W, PC8_W, AO_W, DR_W, RegW_W, exc_W
    );
endinterface

// File: rtl/mem_wb_stage_load_extend.sv
// Selects the addressed byte/halfword of a memory word and sign- or
// zero-extends it according to the load opcode.
module load_extend
    import mips_defs::*;
(
    input  logic [31:0] word_i,
    input  logic [1:0]  offset_i,
    input  logic [5:0]  op_i,
    output logic [31:0] data_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        data_o   = word_i;
        byte_sel = word_i[8*offset_i +: 8];
        half_sel = offset_i[1] ? word_i[31:16] : word_i[15:0];
        case (op_i)
            OP_LB:   data_o = {{24{byte_sel[7]}}, byte_sel};
            OP_LBU:  data_o = {24'd0, byte_sel};
            OP_LH:   data_o = {{16{half_sel[15]}}, half_sel};
            OP_LHU:  data_o = {16'd0, half_sel};
            default: data_o = word_i;
        endcase
    end

endmodule

// File: rtl/mem_wb_stage.sv
// MIPS memory stage: data memory with aligned byte/half/word access,
// address-fault detection, and the MEM/WB pipeline register.
module mem_wb_stage
    import mips_defs::*;
#(
    parameter int DM_WORDS = 1024,
    parameter int DM_AW    = 10
) (
    input  logic                 clk,
    input  logic                 reset,
    mem_wb_stage_if.slave        bus
);

    logic [5:0]       op;
    mem_size_e        size;
    logic             is_load;
    logic             is_store;
    logic             misalign;
    logic             out_of_range;
    logic             fault;
    logic [DM_AW-1:0] widx;
    logic [31:0]      rdata;
    logic [31:0]      ext_data;

    logic [3:0]       dm_be;
    logic [31:0]      dm_wdata;
    logic             dm_we;

    logic [31:0]      dm_q [DM_WORDS];
    wb_reg_t          wb_d;
    wb_reg_t          wb_q;

    always_comb begin
        op           = bus.instr_M[31:26];
        size         = access_size(op);
        is_load      = is_load_op(op);
        is_store     = is_store_op(op);
        misalign     = ((size == SZ_WORD) && (bus.AO_M[1:0] != 2'b00)) ||
                       ((size == SZ_HALF) && bus.AO_M[0]);
        out_of_range = |bus.AO_M[31:DM_AW+2];
        fault        = (is_load || is_store) && (misalign || out_of_range);
        widx         = bus.AO_M[DM_AW+1:2];
    end

    // Store data is replicated across lanes so the byte enables alone pick the target.
    always_comb begin
        dm_be    = 4'b0000;
        dm_wdata = bus.MEMD_M;
        case (size)
            SZ_WORD: dm_be = 4'b1111;
            SZ_HALF: begin
                dm_be    = bus.AO_M[1] ? 4'b1100 : 4'b0011;
                dm_wdata = {2{bus.MEMD_M[15:0]}};
            end
            SZ_BYTE: begin
                dm_be    = 4'b0001 << bus.AO_M[1:0];
                dm_wdata = {4{bus.MEMD_M[7:0]}};
            end
            default: dm_be = 4'b0000;
        endcase
        dm_we = is_store && !fault && reset;
    end

    assign rdata = dm_q[widx];

    load_extend u_load_extend (
        .word_i   (rdata),
        .offset_i (bus.AO_M[1:0]),
        .op_i     (op),
        .data_o   (ext_data)
    );

    always_comb begin
        wb_d.instr = bus.instr_M;
        wb_d.pc4   = bus.PC4_M;
        wb_d.pc8   = bus.PC8_M;
        wb_d.ao    = bus.AO_M;
        wb_d.dr    = (is_load && !fault) ? ext_data : 32'd0;
        wb_d.regw  = (is_load && fault) ? 1'b0 : bus.RegW_M;
        wb_d.exc   = !fault  ? EXC_NONE :
                     is_load ? EXC_ADEL : EXC_ADES;
    end

    // NOTE: the data memory has no reset; contents survive reset and only the pipeline register clears.
    always_ff @(posedge clk) begin
        if (dm_we) begin
            for (int lane = 0; lane < 4; lane++) begin
                if (dm_be[lane]) begin
                    dm_q[widx][8*lane +: 8] <= dm_wdata[8*lane +: 8];
                end
            end
        end
    end

    // NOTE: state is updated with non-blocking assignments so all flops sample pre-edge values.
    always_ff @(posedge clk) begin
        if (!reset) begin
            wb_q <= '0;
        end else begin
            wb_q <= wb_d;
        end
    end

    assign bus.instr_W = wb_q.instr;
    assign bus.PC4_W   = wb_q.pc4;
    assign bus.PC8_W   = wb_q.pc8;
    assign bus.AO_W    = wb_q.ao;
    assign bus.DR_W    = wb_q.dr;
    assign bus.RegW_W  = wb_q.regw;
    assign bus.exc_W   = wb_q.exc;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Scoreboard bench for mem_wb_stage: a byte-addressed reference memory
// predicts each W-stage result; a monitor compares one entry per cycle.
module tb_mem_wb_stage;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    mem_wb_stage_if bus ();

    mem_wb_stage #(
        .DM_WORDS (1024),
        .DM_AW    (10)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc4;
        logic [31:0] pc8;
        logic [31:0] ao;
        logic [31:0] dr;
        logic        regw;
        logic [1:0]  exc;
    } exp_t;

    exp_t        sb_q[$];
    logic [7:0]  model_mem [4096];
    int          checks   = 0;
    int          failures = 0;

    localparam logic [5:0] OPS [9] = '{6'h23, 6'h21, 6'h25, 6'h20, 6'h24,
                                       6'h2B, 6'h29, 6'h28, 6'h00};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drive one M-stage instruction at the falling edge and predict its W result.
    task automatic drive(input logic rst_v, input logic [31:0] instr, input logic [31:0] ao,
                         input logic [31:0] memd, input logic regw, input logic [31:0] pc4);
        exp_t        e;
        logic [5:0]  op;
        int          size;
        bit          ld, st, sgn, flt;
        logic [31:0] val;
        @(negedge clk);
        reset       = rst_v;
        bus.instr_M = instr;
        bus.PC4_M   = pc4;
        bus.PC8_M   = pc4 + 32'd4;
        bus.AO_M    = ao;
        bus.MEMD_M  = memd;
        bus.RegW_M  = regw;
        e = '{instr: 32'd0, pc4: 32'd0, pc8: 32'd0, ao: 32'd0, dr: 32'd0, regw: 1'b0, exc: 2'd0};
        if (rst_v) begin
            op = instr[31:26];
            ld = 0; st = 0; sgn = 0; size = 4;
            case (op)
                6'h23: begin ld = 1; size = 4; end
                6'h21: begin ld = 1; size = 2; sgn = 1; end
                6'h25: begin ld = 1; size = 2; end
                6'h20: begin ld = 1; size = 1; sgn = 1; end
                6'h24: begin ld = 1; size = 1; end
                6'h2B: begin st = 1; size = 4; end
                6'h29: begin st = 1; size = 2; end
                6'h28: begin st = 1; size = 1; end
                default: ;
            endcase
            flt = (ld || st) && ((ao >= 32'd4096) || ((ao % size) != 0));
            e.instr = instr;
            e.pc4   = pc4;
            e.pc8   = pc4 + 32'd4;
            e.ao    = ao;
            e.regw  = (ld && flt) ? 1'b0 : regw;
            e.exc   = !flt ? 2'd0 : (ld ? 2'd1 : 2'd2);
            if (ld && !flt) begin
                val = 32'd0;
                for (int i = 0; i < size; i++) val |= 32'(model_mem[ao + i]) << (8 * i);
                if (sgn && val[8*size-1]) val |= 32'hFFFF_FFFF << (8 * size);
                e.dr = val;
            end
            if (st && !flt) begin
                for (int i = 0; i < size; i++) model_mem[ao + i] = memd[8*i +: 8];
            end
        end
        sb_q.push_back(e);
    endtask

    function automatic logic [31:0] mk_instr(input logic [5:0] op);
        logic [31:0] r;
        r = $urandom();
        if (op == 6'h00) return {6'h00, r[25:6], 6'h21};
        return {op, r[25:0]};
    endfunction

    // Monitor: the pipeline presents a result every cycle after an issue.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                check("instr_W", bus.instr_W, e.instr);
                check("PC4_W",   bus.PC4_W,   e.pc4);
                check("PC8_W",   bus.PC8_W,   e.pc8);
                check("AO_W",    bus.AO_W,    e.ao);
                if (!(e.instr[31:26] inside {6'h2B, 6'h29, 6'h28}))
                    check("DR_W", bus.DR_W, e.dr);
                check("RegW_W",  32'(bus.RegW_W), 32'(e.regw));
                check("exc_W",   32'(bus.exc_W),  32'(e.exc));
            end
        end
    end

    initial begin
        logic [5:0]  op;
        logic [31:0] ao;
        int          sel;
        bus.instr_M = '0; bus.PC4_M = '0; bus.PC8_M = '0;
        bus.AO_M    = '0; bus.MEMD_M = '0; bus.RegW_M = 1'b0;

        // Power-up reset with a store in M: outputs clear, no write.
        drive(0, mk_instr(6'h2B), 32'h10, 32'h1234_5678, 1, $urandom());
        drive(0, mk_instr(6'h2B), 32'h10, 32'h1234_5678, 1, $urandom());

        // Establish known contents for the low 64 bytes.
        for (int w = 0; w < 16; w++)
            drive(1, mk_instr(6'h2B), 32'(w * 4), $urandom(), 0, $urandom());

        // Directed scenarios.
        drive(1, mk_instr(6'h2B), 32'h10, 32'hDEAD_BEEF, 0, $urandom());
        drive(1, mk_instr(6'h23), 32'h10, 32'h0, 1, $urandom());
        drive(1, mk_instr(6'h28), 32'h13, 32'h0000_00AB, 0, $urandom());
        drive(1, mk_instr(6'h20), 32'h13, 32'h0, 1, $urandom());
        drive(1, mk_instr(6'h24), 32'h13, 32'h0, 1, $urandom());
        drive(1, mk_instr(6'h23), 32'h10, 32'h0, 1, $urandom());
        drive(1, mk_instr(6'h29), 32'h22, 32'h0000_8001, 0, $urandom());
        drive(1, mk_instr(6'h21), 32'h22, 32'h0, 1, $urandom());
        drive(1, mk_instr(6'h25), 32'h22, 32'h0, 1, $urandom());
        drive(1, mk_instr(6'h23), 32'h11, 32'h0, 1, $urandom());
        drive(1, mk_instr(6'h2B), 32'h1000, 32'hCAFE_F00D, 0, $urandom());
        drive(1, mk_instr(6'h23), 32'h0, 32'h0, 1, $urandom());
        drive(1, mk_instr(6'h00), 32'h5, 32'h0, 1, 32'h3004);

        // Mid-sequence reset drops the store in M; prior contents persist.
        drive(0, mk_instr(6'h2B), 32'h14, 32'h55AA_55AA, 1, $urandom());
        drive(0, mk_instr(6'h2B), 32'h14, 32'h55AA_55AA, 1, $urandom());
        drive(1, mk_instr(6'h23), 32'h14, 32'h0, 1, $urandom());

        // Randomised mix, including misaligned and out-of-range addresses.
        for (int n = 0; n < 400; n++) begin
            sel = $urandom_range(0, 8);
            op  = OPS[sel];
            if ($urandom_range(0, 9) == 0) ao = 32'h1000 | 32'($urandom_range(0, 32'hFFFF));
            else                            ao = 32'($urandom_range(0, 63));
            drive(1, mk_instr(op), ao, $urandom(),
                  (sel < 5) ? 1'b1 : (sel < 8) ? 1'b0 : 1'($urandom_range(0, 1)),
                  $urandom());
        end

        @(posedge clk);
        #2;
        check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
